// File: rtl/lab_vector_sequencer.sv
// rtl/lab_vector_sequencer.sv - vector-table self-test sequencer for lab circuits
// Applies stored stimuli to a neighbouring DUT, waits a settle time, and scores the responses.
module lab_vector_sequencer #(
   parameter int IN_W       = 4,
   parameter int OUT_W      = 1,
   parameter int DEPTH      = 16,
   parameter int SETTLE_CYC = 1,
   localparam int AW        = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load_we,
   input  logic [AW-1:0]    load_addr,
   input  logic [IN_W-1:0]  load_stim,
   input  logic [OUT_W-1:0] load_exp,
   input  logic [AW:0]      num_vec,
   input  logic             start,
   input  logic             abort,
   output logic [IN_W-1:0]  dut_in,
   input  logic [OUT_W-1:0] dut_out,
   output logic             busy,
   output logic             done,
   output logic             pass,
   output logic [AW:0]      err_count,
   output logic [AW-1:0]    first_err_idx
);

   localparam int CW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
   localparam logic [AW:0] NMAX = (AW+1)'(DEPTH);

   typedef enum logic [2:0] {IDLE, APPLY, SETTLE, CHECK, DONE} state_t;

   state_t            state;
   logic [AW-1:0]     idx;
   logic [AW:0]       n;
   logic [CW-1:0]     cnt;
   logic [IN_W-1:0]   stim_mem [DEPTH];
   logic [OUT_W-1:0]  exp_mem  [DEPTH];

   // Table RAM is deliberately not reset so vectors survive a reset pulse.
   always_ff @(posedge clk) begin
      if (load_we && !busy) begin
         stim_mem[load_addr] <= load_stim;
         exp_mem[load_addr]  <= load_exp;
      end
   end

   assign pass = done && (err_count == '0);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state         <= IDLE;
         idx           <= '0;
         n             <= '0;
         cnt           <= '0;
         dut_in        <= '0;
         busy          <= 1'b0;
         done          <= 1'b0;
         err_count     <= '0;
         first_err_idx <= '0;
      end else if (abort) begin
         state <= IDLE;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  idx           <= '0;
                  err_count     <= '0;
                  first_err_idx <= '0;
                  if (num_vec == '0) begin
                     n     <= '0;
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end else begin
                     n     <= (num_vec > NMAX) ? NMAX : num_vec;
                     state <= APPLY;
                     busy  <= 1'b1;
                     done  <= 1'b0;
                  end
               end
            end
            APPLY: begin
               dut_in <= stim_mem[idx];
               cnt    <= CW'(SETTLE_CYC - 1);
               state  <= SETTLE;
            end
            SETTLE: begin
               if (cnt == '0) state <= CHECK;
               else           cnt   <= cnt - 1'b1;
            end
            CHECK: begin
               if (dut_out != exp_mem[idx]) begin
                  if (err_count != '1) err_count <= err_count + 1'b1;
                  if (err_count == '0) first_err_idx <= idx;
               end
               if ({1'b0, idx} == n - (AW+1)'(1)) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  idx   <= idx + 1'b1;
                  state <= APPLY;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lab_vector_sequencer.sv
// tb/tb_lab_vector_sequencer.sv - directed table-driven bench for lab_vector_sequencer
// The lab circuit under test is a 4-input parity gate driven by the sequencer.
module tb_lab_vector_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       load_we;
   logic [3:0] load_addr;
   logic [3:0] load_stim;
   logic [0:0] load_exp;
   logic [4:0] num_vec;
   logic       start;
   logic       abort;
   logic [3:0] dut_in;
   logic [0:0] dut_out;
   logic       busy;
   logic       done;
   logic       pass;
   logic [4:0] err_count;
   logic [3:0] first_err_idx;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   assign dut_out = ^dut_in;

   lab_vector_sequencer dut (
      .clk           (clk),
      .reset         (reset),
      .load_we       (load_we),
      .load_addr     (load_addr),
      .load_stim     (load_stim),
      .load_exp      (load_exp),
      .num_vec       (num_vec),
      .start         (start),
      .abort         (abort),
      .dut_in        (dut_in),
      .dut_out       (dut_out),
      .busy          (busy),
      .done          (done),
      .pass          (pass),
      .err_count     (err_count),
      .first_err_idx (first_err_idx)
   );

   typedef struct {
      logic [4:0]  nv;
      logic [15:0] mask;
      int          cycles;
      int          errs;
      int          fei;
      int          pss;
      int          last_in;
   } case_t;

   case_t cases [7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      tests++;
      if (act !== expv) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic load_table(input logic [15:0] mask);
      for (int i = 0; i < 16; i++) begin
         logic [3:0] s;
         s         = 4'(i);
         load_we   = 1'b1;
         load_addr = s;
         load_stim = s;
         load_exp  = (^s) ^ mask[i];
         tick();
      end
      load_we = 1'b0;
   endtask

   task automatic run(input logic [4:0] nv, output int cyc);
      num_vec = nv;
      start   = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      while (!done && cyc < 300) begin
         tick();
         cyc++;
      end
   endtask

   initial begin
      int cyc;

      reset = 1'b0; load_we = 1'b0; load_addr = '0; load_stim = '0; load_exp = '0;
      num_vec = '0; start = 1'b0; abort = 1'b0;

      cases[0] = '{5'd4,  16'h0000, 12, 0,  0, 1, 4'd3};
      cases[1] = '{5'd4,  16'h000A, 12, 2,  1, 0, 4'd3};
      cases[2] = '{5'd0,  16'h0000, 0,  0,  0, 1, 4'd3};
      cases[3] = '{5'd21, 16'h0000, 48, 0,  0, 1, 4'd15};
      cases[4] = '{5'd16, 16'h8020, 48, 2,  5, 0, 4'd15};
      cases[5] = '{5'd1,  16'h0001, 3,  1,  0, 0, 4'd0};
      cases[6] = '{5'd16, 16'hFFFF, 48, 16, 0, 0, 4'd15};

      tick(); tick();
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_err", err_count, 0);
      chk("rst_dutin", dut_in, 0);
      chk("rst_fei", first_err_idx, 0);
      reset = 1'b1;
      tick();

      foreach (cases[k]) begin
         load_table(cases[k].mask);
         run(cases[k].nv, cyc);
         chk($sformatf("c%0d_cycles", k), cyc, cases[k].cycles);
         chk($sformatf("c%0d_err", k), err_count, cases[k].errs);
         chk($sformatf("c%0d_pass", k), pass, cases[k].pss);
         chk($sformatf("c%0d_busy", k), busy, 0);
         chk($sformatf("c%0d_dutin", k), dut_in, cases[k].last_in);
         if (cases[k].errs != 0)
            chk($sformatf("c%0d_fei", k), first_err_idx, cases[k].fei);
      end

      // start and table writes while busy must both be ignored
      load_table(16'h0000);
      num_vec = 5'd16;
      start   = 1'b1;
      tick();
      start = 1'b0;
      cyc   = 0;
      while (!done && cyc < 300) begin
         start     = (cyc == 10);
         num_vec   = (cyc == 10) ? 5'd2 : 5'd16;
         load_we   = (cyc == 5);
         load_addr = 4'd2;
         load_stim = 4'hF;
         load_exp  = 1'b1;
         tick();
         cyc++;
      end
      start = 1'b0; load_we = 1'b0;
      chk("busy_start_cycles", cyc, 48);
      chk("busy_start_err", err_count, 0);
      chk("busy_start_dutin", dut_in, 15);
      run(5'd4, cyc);
      chk("busy_load_err", err_count, 0);
      chk("busy_load_pass", pass, 1);

      // abort during vector 2, then a clean rerun
      num_vec = 5'd4;
      start   = 1'b1;
      tick();
      start = 1'b0;
      repeat (7) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("abort_busy", busy, 0);
      chk("abort_done", done, 0);
      chk("abort_dutin", dut_in, 2);
      chk("abort_err", err_count, 0);
      tick();
      chk("abort_idle", busy, 0);
      run(5'd4, cyc);
      chk("abort_rerun_cycles", cyc, 12);
      chk("abort_rerun_pass", pass, 1);

      // asynchronous reset mid-run
      load_table(16'h0010);
      num_vec = 5'd16;
      start   = 1'b1;
      tick();
      start = 1'b0;
      repeat (20) tick();
      chk("pre_rst_busy", busy, 1);
      chk("pre_rst_err", err_count, 1);
      #3 reset = 1'b0;
      #1;
      chk("async_busy", busy, 0);
      chk("async_done", done, 0);
      chk("async_dutin", dut_in, 0);
      chk("async_err", err_count, 0);
      tick();
      reset = 1'b1;
      tick();
      chk("post_rst_done", done, 0);
      run(5'd16, cyc);
      chk("post_rst_cycles", cyc, 48);
      chk("post_rst_err", err_count, 1);
      chk("post_rst_fei", first_err_idx, 4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
